// File: rtl/bp_mem_channel_interleaver_if.sv
// bp_mem_channel_interleaver_if: core command/response port plus the per-channel command/response ports
// Ports: cmd_*/resp_* face the core, chan_cmd_*/chan_resp_* face the channel bridges,
// outstanding_o reports issued-but-unreturned commands. The interleaver uses the slave modport.
interface bp_mem_channel_interleaver_if #(
    parameter int num_channels_p = 2,
    parameter int msg_width_p = 128,
    parameter int addr_width_p = 40,
    parameter int max_outstanding_p = 8
);
    logic [msg_width_p-1:0] cmd_i;
    logic [addr_width_p-1:0] cmd_addr_i;
    logic cmd_v_i;
    logic cmd_ready_o;
    logic [num_channels_p-1:0][msg_width_p-1:0] chan_cmd_o;
    logic [num_channels_p-1:0] chan_cmd_v_o;
    logic [num_channels_p-1:0] chan_cmd_ready_i;
    logic [num_channels_p-1:0][msg_width_p-1:0] chan_resp_i;
    logic [num_channels_p-1:0] chan_resp_v_i;
    logic [num_channels_p-1:0] chan_resp_yumi_o;
    logic [msg_width_p-1:0] resp_o;
    logic resp_v_o;
    logic resp_yumi_i;
    logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o;
    modport master (
        output cmd_i, cmd_addr_i, cmd_v_i, chan_cmd_ready_i, chan_resp_i, chan_resp_v_i, resp_yumi_i,
        input cmd_ready_o, chan_cmd_o, chan_cmd_v_o, chan_resp_yumi_o, resp_o, resp_v_o, outstanding_o
    );
    modport slave (
        input cmd_i, cmd_addr_i, cmd_v_i, chan_cmd_ready_i, chan_resp_i, chan_resp_v_i, resp_yumi_i,
        output cmd_ready_o, chan_cmd_o, chan_cmd_v_o, chan_resp_yumi_o, resp_o, resp_v_o, outstanding_o
    );
endinterface

// File: rtl/bp_mem_channel_interleaver.sv
// bp_mem_channel_interleaver: steers core commands to N memory channels by address and returns responses in issue order
// Ports: clk_i, reset_i (sync, active high); bus (slave modport) carries the core command/response
// handshakes, the per-channel command/response handshakes and the outstanding count.
module bp_mem_channel_interleaver #(
    parameter int num_channels_p = 2,
    parameter int msg_width_p = 128,
    parameter int addr_width_p = 40,
    parameter int addr_lsb_p = 6,
    parameter bit interleave_p = 1'b1,
    parameter int max_outstanding_p = 8
) (
    input logic clk_i,
    input logic reset_i,
    bp_mem_channel_interleaver_if.slave bus
);
    localparam int lg_ch = num_channels_p == 1 ? 1 : $clog2(num_channels_p);
    localparam int ptr_w = $clog2(max_outstanding_p);
    localparam int cnt_w = $clog2(max_outstanding_p + 1);
    localparam logic [ptr_w-1:0] last = ptr_w'(max_outstanding_p - 1);
    localparam logic [cnt_w-1:0] depth = cnt_w'(max_outstanding_p);

    logic [lg_ch-1:0] ord [max_outstanding_p];
    logic [ptr_w-1:0] wr_ptr, rd_ptr;
    logic [cnt_w-1:0] count;
    logic reset_q;
    logic [lg_ch-1:0] sel, head;
    logic live, full, empty, push, pop;

    if (num_channels_p == 1) begin : g_one
        assign sel = '0;
    end else if (interleave_p) begin : g_interleave
        assign sel = bus.cmd_addr_i[addr_lsb_p +: lg_ch];
    end else begin : g_region
        assign sel = bus.cmd_addr_i[addr_width_p-1 -: lg_ch];
    end

    // outputs stay quiet during reset and for one cycle after it
    assign live = ~reset_i & ~reset_q;
    assign full = count == depth;
    assign empty = count == '0;
    assign head = ord[rd_ptr];

    assign bus.cmd_ready_o = live & ~full & bus.chan_cmd_ready_i[sel];
    assign push = bus.cmd_v_i & bus.cmd_ready_o;
    assign bus.resp_o = bus.chan_resp_i[head];
    assign bus.resp_v_o = live & ~empty & bus.chan_resp_v_i[head];
    assign pop = live & ~empty & bus.resp_yumi_i;
    assign bus.outstanding_o = count;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
        assign bus.chan_cmd_o[c] = bus.cmd_i;
        assign bus.chan_cmd_v_o[c] = live & ~full & bus.cmd_v_i & (sel == lg_ch'(c));
        assign bus.chan_resp_yumi_o[c] = pop & (head == lg_ch'(c));
    end

    always_ff @(posedge clk_i) begin
        reset_q <= reset_i;
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == last ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == last ? '0 : rd_ptr + 1'b1;
            count <= count + cnt_w'(push) - cnt_w'(pop);
        end
    end

    always_ff @(posedge clk_i)
        if (push) ord[wr_ptr] <= sel;

    always_ff @(posedge clk_i)
        if (!reset_i) assert (!(bus.resp_yumi_i && empty)) else $error("response dequeued with no outstanding command");
endmodule

// File: tb/tb_bp_mem_channel_interleaver.sv
// tb_bp_mem_channel_interleaver: scoreboard bench for the channel interleaver (2-ch interleaved and 4-ch contiguous)
module tb_bp_mem_channel_interleaver;
    localparam int mw = 32;

    typedef struct packed {
        logic ch;
        logic [mw-1:0] data;
    } exp_t;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    logic [1:0] resp_en = 2'b00;
    exp_t sb[$];
    logic [mw-1:0] chq0[$], chq1[$];
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    bp_mem_channel_interleaver_if #(.num_channels_p(2), .msg_width_p(mw), .addr_width_p(40), .max_outstanding_p(4)) ia ();
    bp_mem_channel_interleaver_if #(.num_channels_p(4), .msg_width_p(mw), .addr_width_p(40), .max_outstanding_p(8)) ib ();

    bp_mem_channel_interleaver #(
        .num_channels_p(2), .msg_width_p(mw), .addr_width_p(40), .addr_lsb_p(6), .interleave_p(1'b1), .max_outstanding_p(4)
    ) dut_a (.clk_i(clk_i), .reset_i(reset_i), .bus(ia));

    bp_mem_channel_interleaver #(
        .num_channels_p(4), .msg_width_p(mw), .addr_width_p(40), .addr_lsb_p(6), .interleave_p(1'b0), .max_outstanding_p(8)
    ) dut_b (.clk_i(clk_i), .reset_i(reset_i), .bus(ib));

    function automatic logic [mw-1:0] resp_of(input logic [mw-1:0] cmd);
        return cmd ^ 32'hA5A5_5A5A;
    endfunction

    task automatic drive_resp();
        ia.chan_resp_v_i[0] = resp_en[0] && chq0.size() > 0;
        ia.chan_resp_i[0] = chq0.size() > 0 ? chq0[0] : '0;
        ia.chan_resp_v_i[1] = resp_en[1] && chq1.size() > 0;
        ia.chan_resp_i[1] = chq1.size() > 0 ? chq1[0] : '0;
    endtask

    task automatic push_exp(input logic [mw-1:0] cmd, input logic ch);
        sb.push_back(exp_t'{ch: ch, data: resp_of(cmd)});
        if (ch) chq1.push_back(resp_of(cmd));
        else chq0.push_back(resp_of(cmd));
    endtask

    task automatic pop_chan(input logic ch);
        logic [mw-1:0] d;
        if (ch) d = chq1.pop_front();
        else d = chq0.pop_front();
    endtask

    task automatic tick();
        @(negedge clk_i);
        ia.resp_yumi_i = 1'b0;
        drive_resp();
        #1;
    endtask

    task automatic test_reset();
        ia.cmd_v_i = 1'b1; ia.cmd_addr_i = '0; ia.cmd_i = 32'h1; ia.chan_cmd_ready_i = '1; ia.resp_yumi_i = 1'b0;
        ib.cmd_v_i = 1'b1; ib.cmd_addr_i = '0; ib.cmd_i = 32'h1; ib.chan_cmd_ready_i = '1; ib.resp_yumi_i = 1'b0;
        ib.chan_resp_i = '0; ib.chan_resp_v_i = '0;
        reset_i = 1'b1;
        resp_en = 2'b11;
        repeat (2) tick();
        ia.chan_resp_v_i = '1;
        #1;
        n_tests++; if (ia.cmd_ready_o !== 1'b0 || ia.chan_cmd_v_o !== 2'b00) begin n_fail++; $display("FAIL reset_cmd: ready=%b v=%b want 0/00", ia.cmd_ready_o, ia.chan_cmd_v_o); end
        n_tests++; if (ia.resp_v_o !== 1'b0 || ia.chan_resp_yumi_o !== 2'b00) begin n_fail++; $display("FAIL reset_resp: v=%b yumi=%b want 0/00", ia.resp_v_o, ia.chan_resp_yumi_o); end
        n_tests++; if (ia.outstanding_o !== 3'd0 || ib.outstanding_o !== 4'd0) begin n_fail++; $display("FAIL reset_count: a=%0d b=%0d want 0/0", ia.outstanding_o, ib.outstanding_o); end
        tick();
        reset_i = 1'b0;
        #1;
        n_tests++; if (ia.cmd_ready_o !== 1'b0 || ia.chan_cmd_v_o !== 2'b00 || ib.chan_cmd_v_o !== 4'b0000) begin n_fail++; $display("FAIL post_reset_quiet: ready=%b va=%b vb=%b want 0", ia.cmd_ready_o, ia.chan_cmd_v_o, ib.chan_cmd_v_o); end
        tick();
        ia.cmd_v_i = 1'b0;
        ib.cmd_v_i = 1'b0;
        #1;
        n_tests++; if (ia.outstanding_o !== 3'd0 || ib.outstanding_o !== 4'd0) begin n_fail++; $display("FAIL post_reset_count: a=%0d b=%0d want 0/0", ia.outstanding_o, ib.outstanding_o); end
    endtask

    task automatic test_interleave();
        logic [mw-1:0] cmd;
        logic ch;
        resp_en = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            ch = i[0];
            cmd = 32'h100 + 32'(i);
            ia.cmd_v_i = 1'b1; ia.cmd_addr_i = 40'(i * 64); ia.cmd_i = cmd;
            #1;
            n_tests++; if (ia.chan_cmd_v_o !== (ch ? 2'b10 : 2'b01) || ia.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL interleave_route[%0d]: v=%b ready=%b want %b/1", i, ia.chan_cmd_v_o, ia.cmd_ready_o, ch ? 2'b10 : 2'b01); end
            n_tests++; if (ia.chan_cmd_o[0] !== cmd || ia.chan_cmd_o[1] !== cmd) begin n_fail++; $display("FAIL broadcast[%0d]: %h %h want %h", i, ia.chan_cmd_o[0], ia.chan_cmd_o[1], cmd); end
            push_exp(cmd, ch);
        end
        tick();
        ia.cmd_v_i = 1'b0;
        #1;
        n_tests++; if (ia.outstanding_o !== 3'd3) begin n_fail++; $display("FAIL interleave_count: got %0d want 3", ia.outstanding_o); end
    endtask

    task automatic test_in_order_return();
        exp_t e;
        int guard = 0;
        resp_en = 2'b11;
        while (sb.size() > 0 && guard < 40) begin
            guard++;
            tick();
            n_tests++; if (ia.outstanding_o !== 3'(sb.size())) begin n_fail++; $display("FAIL drain_count: got %0d want %0d", ia.outstanding_o, sb.size()); end
            n_tests++;
            if (ia.resp_v_o !== 1'b1) begin
                n_fail++; $display("FAIL drain_valid: got %b want 1", ia.resp_v_o);
            end else begin
                e = sb.pop_front();
                if (ia.resp_o !== e.data) begin n_fail++; $display("FAIL drain_data: got %h want %h", ia.resp_o, e.data); end
                ia.resp_yumi_i = 1'b1;
                #1;
                n_tests++; if (ia.chan_resp_yumi_o !== (e.ch ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL drain_yumi: got %b want %b", ia.chan_resp_yumi_o, e.ch ? 2'b10 : 2'b01); end
                pop_chan(e.ch);
            end
        end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL drain_timeout: %0d left want 0", sb.size()); end
        tick();
        n_tests++; if (ia.outstanding_o !== 3'd0 || ia.resp_v_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty: count=%0d v=%b want 0/0", ia.outstanding_o, ia.resp_v_o); end
    endtask

    task automatic test_reorder();
        exp_t e;
        resp_en = 2'b00;
        tick();
        ia.cmd_v_i = 1'b1; ia.cmd_addr_i = 40'h0; ia.cmd_i = 32'hAAAA_0001;
        #1;
        push_exp(32'hAAAA_0001, 1'b0);
        tick();
        ia.cmd_addr_i = 40'h40; ia.cmd_i = 32'hBBBB_0002;
        #1;
        push_exp(32'hBBBB_0002, 1'b1);
        resp_en = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            ia.cmd_v_i = 1'b0;
            #1;
            n_tests++; if (ia.chan_resp_v_i !== 2'b10 || ia.resp_v_o !== 1'b0 || ia.chan_resp_yumi_o !== 2'b00) begin n_fail++; $display("FAIL reorder_hold[%0d]: v=%b yumi=%b want 0/00", i, ia.resp_v_o, ia.chan_resp_yumi_o); end
        end
        resp_en = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front();
            n_tests++; if (ia.resp_v_o !== 1'b1 || ia.resp_o !== e.data) begin n_fail++; $display("FAIL reorder_data[%0d]: v=%b data=%h want 1/%h", i, ia.resp_v_o, ia.resp_o, e.data); end
            ia.resp_yumi_i = 1'b1;
            #1;
            n_tests++; if (ia.chan_resp_yumi_o !== (i == 0 ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL reorder_yumi[%0d]: got %b want %b", i, ia.chan_resp_yumi_o, i == 0 ? 2'b01 : 2'b10); end
            pop_chan(e.ch);
        end
        tick();
        n_tests++; if (ia.outstanding_o !== 3'd0) begin n_fail++; $display("FAIL reorder_count: got %0d want 0", ia.outstanding_o); end
    endtask

    task automatic test_full();
        exp_t e;
        logic [mw-1:0] cmd;
        resp_en = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            cmd = 32'h200 + 32'(i);
            ia.cmd_v_i = 1'b1; ia.cmd_addr_i = 40'(i * 64); ia.cmd_i = cmd;
            #1;
            n_tests++; if (ia.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_fill[%0d]: ready=%b want 1", i, ia.cmd_ready_o); end
            push_exp(cmd, i[0]);
        end
        tick();
        ia.cmd_addr_i = 40'h100; ia.cmd_i = 32'h204;
        #1;
        n_tests++; if (ia.outstanding_o !== 3'd4 || ia.cmd_ready_o !== 1'b0 || ia.chan_cmd_v_o !== 2'b00) begin n_fail++; $display("FAIL full_block: count=%0d ready=%b v=%b want 4/0/00", ia.outstanding_o, ia.cmd_ready_o, ia.chan_cmd_v_o); end
        resp_en = 2'b11;
        drive_resp();
        #1;
        e = sb.pop_front();
        n_tests++; if (ia.resp_v_o !== 1'b1 || ia.resp_o !== e.data) begin n_fail++; $display("FAIL full_pop: v=%b data=%h want 1/%h", ia.resp_v_o, ia.resp_o, e.data); end
        ia.resp_yumi_i = 1'b1;
        #1;
        n_tests++; if (ia.cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_same_cycle: ready=%b want 0", ia.cmd_ready_o); end
        pop_chan(e.ch);
        tick();
        n_tests++; if (ia.cmd_ready_o !== 1'b1 || ia.outstanding_o !== 3'd3) begin n_fail++; $display("FAIL full_reopen: ready=%b count=%0d want 1/3", ia.cmd_ready_o, ia.outstanding_o); end
        push_exp(32'h204, 1'b0);
        tick();
        ia.cmd_v_i = 1'b0;
        #1;
        n_tests++; if (ia.outstanding_o !== 3'd4) begin n_fail++; $display("FAIL full_refill: count=%0d want 4", ia.outstanding_o); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [mw-1:0] cmd;
        resp_en = 2'b11;
        for (int i = 0; i < 12 && sb.size() > 0; i++) begin
            tick();
            n_tests++; if (ia.outstanding_o !== 3'(sb.size())) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, ia.outstanding_o, sb.size()); end
            n_tests++; if (ia.resp_v_o !== 1'b1 || ia.resp_o !== sb[0].data) begin n_fail++; $display("FAIL b2b_resp[%0d]: v=%b data=%h want 1/%h", i, ia.resp_v_o, ia.resp_o, sb[0].data); end
            e = sb.pop_front();
            ia.resp_yumi_i = 1'b1;
            pop_chan(e.ch);
            cmd = 32'h300 + 32'(i);
            ia.cmd_v_i = i >= 1 && i <= 6;
            ia.cmd_addr_i = 40'(i * 64); ia.cmd_i = cmd;
            #1;
            if (ia.cmd_v_i) begin
                n_tests++; if (ia.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_issue[%0d]: ready=%b want 1", i, ia.cmd_ready_o); end
                push_exp(cmd, i[0]);
            end
        end
        tick();
        ia.cmd_v_i = 1'b0;
        #1;
        n_tests++; if (sb.size() != 0 || ia.outstanding_o !== 3'd0) begin n_fail++; $display("FAIL b2b_end: left=%0d count=%0d want 0/0", sb.size(), ia.outstanding_o); end
    endtask

    task automatic test_backpressure();
        resp_en = 2'b00;
        ia.chan_cmd_ready_i = 2'b01;
        tick();
        ia.cmd_v_i = 1'b1; ia.cmd_addr_i = 40'h40; ia.cmd_i = 32'h400;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_tests++; if (ia.chan_cmd_v_o !== 2'b10 || ia.cmd_ready_o !== 1'b0 || ia.outstanding_o !== 3'd0) begin n_fail++; $display("FAIL bp_hold[%0d]: v=%b ready=%b count=%0d want 10/0/0", i, ia.chan_cmd_v_o, ia.cmd_ready_o, ia.outstanding_o); end
            tick();
        end
        ia.chan_cmd_ready_i = 2'b11;
        #1;
        n_tests++; if (ia.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release: ready=%b want 1", ia.cmd_ready_o); end
        push_exp(32'h400, 1'b1);
        tick();
        ia.cmd_v_i = 1'b0;
        #1;
        n_tests++; if (ia.outstanding_o !== 3'd1) begin n_fail++; $display("FAIL bp_count: got %0d want 1", ia.outstanding_o); end
    endtask

    task automatic test_contiguous();
        tick();
        ib.cmd_v_i = 1'b1; ib.cmd_addr_i = 40'hC0_0000_0000; ib.cmd_i = 32'h500;
        #1;
        n_tests++; if (ib.chan_cmd_v_o !== 4'b1000 || ib.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL contig_top: v=%b ready=%b want 1000/1", ib.chan_cmd_v_o, ib.cmd_ready_o); end
        tick();
        ib.cmd_addr_i = 40'h40_0000_0040;
        #1;
        n_tests++; if (ib.chan_cmd_v_o !== 4'b0010) begin n_fail++; $display("FAIL contig_ch1: v=%b want 0010", ib.chan_cmd_v_o); end
        tick();
        ib.cmd_v_i = 1'b0;
        #1;
        n_tests++; if (ib.outstanding_o !== 4'd2) begin n_fail++; $display("FAIL contig_count: got %0d want 2", ib.outstanding_o); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        resp_en = 2'b00;
        for (int i = 0; i < 2; i++) begin
            tick();
            ia.cmd_v_i = 1'b1; ia.cmd_addr_i = 40'(i * 128); ia.cmd_i = 32'h600 + 32'(i);
            #1;
            push_exp(32'h600 + 32'(i), 1'b0);
        end
        tick();
        ia.cmd_v_i = 1'b0;
        #1;
        n_tests++; if (ia.outstanding_o !== 3'd3) begin n_fail++; $display("FAIL mid_pre: count=%0d want 3", ia.outstanding_o); end
        resp_en = 2'b11;
        tick();
        reset_i = 1'b1;
        #1;
        n_tests++; if (ia.chan_resp_v_i !== 2'b11 || ia.resp_v_o !== 1'b0 || ia.cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset: v=%b ready=%b want 0/0", ia.resp_v_o, ia.cmd_ready_o); end
        tick();
        reset_i = 1'b0;
        sb.delete(); chq0.delete(); chq1.delete();
        ia.chan_resp_v_i = 2'b11;
        #1;
        n_tests++; if (ia.outstanding_o !== 3'd0 || ia.resp_v_o !== 1'b0) begin n_fail++; $display("FAIL mid_after: count=%0d v=%b want 0/0", ia.outstanding_o, ia.resp_v_o); end
        tick();
        ia.chan_resp_v_i = 2'b11;
        ia.cmd_v_i = 1'b1; ia.cmd_addr_i = 40'h40; ia.cmd_i = 32'h700;
        #1;
        n_tests++; if (ia.resp_v_o !== 1'b0 || ia.cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_fresh: v=%b ready=%b want 0/1", ia.resp_v_o, ia.cmd_ready_o); end
        push_exp(32'h700, 1'b1);
        tick();
        ia.cmd_v_i = 1'b0;
        #1;
        e = sb.pop_front();
        n_tests++; if (ia.outstanding_o !== 3'd1 || ia.resp_v_o !== 1'b1 || ia.resp_o !== e.data) begin n_fail++; $display("FAIL mid_return: count=%0d v=%b data=%h want 1/1/%h", ia.outstanding_o, ia.resp_v_o, ia.resp_o, e.data); end
        ia.resp_yumi_i = 1'b1;
        #1;
        n_tests++; if (ia.chan_resp_yumi_o !== 2'b10) begin n_fail++; $display("FAIL mid_yumi: got %b want 10", ia.chan_resp_yumi_o); end
        pop_chan(e.ch);
        tick();
        n_tests++; if (ia.outstanding_o !== 3'd0) begin n_fail++; $display("FAIL mid_end: count=%0d want 0", ia.outstanding_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_interleave();
        test_in_order_return();
        test_reorder();
        test_full();
        test_back_to_back();
        test_backpressure();
        test_contiguous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_mem_channel_interleaver.md
# bp_mem_channel_interleaver

Parametrised memory-channel interleaver for the BlackParrot tile's uncached memory path. It sits between the core-side BedRock memory command/response port and N per-channel `bp_cce_to_mc_bridge` instances, and generalises the fixed 2-way DRAM split to `num_channels_p` channels. Each command is steered to a channel by address, either interleaved at block granularity or by contiguous region. Responses are returned to the core strictly in issue order, whatever order the channels complete in.

## Interface
- `num_channels_p`, default 2: number of downstream channels. Must be a power of two, ≥1. `lg_ch = $clog2(num_channels_p)`, or 1 when `num_channels_p`=1.
- `msg_width_p`, default 128: width of an opaque command/response message (header plus payload).
- `addr_width_p`, default 40: physical address width.
- `addr_lsb_p`, default 6: lowest address bit of the channel select field in interleave mode (64 B blocks).
- `interleave_p`, default 1: 1 selects `addr[addr_lsb_p +: lg_ch]`; 0 selects `addr[addr_width_p-1 -: lg_ch]`.
- `max_outstanding_p`, default 8: depth of the order FIFO, ≥2.
- `clk_i` in 1: the single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `cmd_i` in `msg_width_p`: core command message.
- `cmd_addr_i` in `addr_width_p`: address of `cmd_i`.
- `cmd_v_i` in 1: command valid.
- `cmd_ready_o` out 1: ready-valid acceptance.
- `chan_cmd_o` out `[num_channels_p][msg_width_p]`: per-channel command. `cmd_i` is broadcast to all channels.
- `chan_cmd_v_o` out `num_channels_p`: per-channel command valid.
- `chan_cmd_ready_i` in `num_channels_p`: per-channel ready. Must not depend on `chan_cmd_v_o`.
- `chan_resp_i` in `[num_channels_p][msg_width_p]`: per-channel response.
- `chan_resp_v_i` in `num_channels_p`: per-channel response valid.
- `chan_resp_yumi_o` out `num_channels_p`: per-channel response dequeue.
- `resp_o` out `msg_width_p`: in-order response to the core.
- `resp_v_o` out 1: response valid.
- `resp_yumi_i` in 1: core dequeue. Legal only when `resp_v_o`=1.
- `outstanding_o` out `$clog2(max_outstanding_p+1)`: number of issued commands whose responses have not been returned.

## Operation
- Channel select: `sel` is computed combinationally from `cmd_addr_i` per `interleave_p`. When `num_channels_p`=1, `sel` is 0.
- Order FIFO: circular buffer of `max_outstanding_p` entries, each `lg_ch` bits, holding the channel ID of every issued command. Head and tail pointers wrap modulo `max_outstanding_p`. A counter tracks occupancy, and `outstanding_o` equals that count.
- Issue:
  - `chan_cmd_v_o[c] = cmd_v_i & (sel==c) & ~full & ~reset_i`.
  - `cmd_ready_o = chan_cmd_ready_i[sel] & ~full & ~reset_i`.
  - Fire means `cmd_v_i & cmd_ready_o`. On fire, push `sel` at the tail.
- Push requires `~full` even when a pop happens in the same cycle. This is deliberately conservative and keeps `cmd_ready_o` independent of `resp_yumi_i`.
- Return:
  - `head` is the channel ID at the FIFO head.
  - `resp_o = chan_resp_i[head]`.
  - `resp_v_o = ~empty & chan_resp_v_i[head]`.
  - `chan_resp_yumi_o[c] = resp_yumi_i & (head==c)`.
  - On `resp_yumi_i`, pop the head.
- Responses valid on non-head channels are held in their channels and not dequeued until they reach the head.
- Simultaneous push and pop (not full): the count is unchanged and both pointers advance.
- Pop when empty is a protocol error. The block asserts (simulation only) and leaves state unchanged.
- A response valid on a channel that has no outstanding entry is ignored and never dequeued.
- Reset:
  - Pointers and count go to 0, so `outstanding_o`=0.
  - `cmd_ready_o`, all `chan_cmd_v_o`, `resp_v_o` and `chan_resp_yumi_o` are 0 while `reset_i`=1 and in the first cycle after reset.
  - A reset mid-operation discards all order state. Channels must be reset alongside this block.

## Timing
- Command path is zero latency: combinational passthrough from `cmd_*` to `chan_cmd_*` in the same cycle.
- Response path is zero latency: combinational from `chan_resp_v_i[head]` to `resp_v_o`.
- A FIFO push is visible in `outstanding_o` the next cycle. A command issued in cycle t can be returned no earlier than cycle t+1.
- Full condition: count==`max_outstanding_p` drops `cmd_ready_o` in the cycle after the last push. The first cycle after a pop from full has `cmd_ready_o`=1.
- Throughput is one issue and one return per cycle, concurrently.

## Test plan
- Interleave routing: `num_channels_p`=2, `addr_lsb_p`=6, addresses 0x0, 0x40, 0x80 with all channels ready -> `chan_cmd_v_o` = 01, 10, 01 on successive cycles; `outstanding_o` ends at 3.
- Reordering: cmd A (0x0) to ch0, then B (0x40) to ch1; ch1 response valid at cycle 5, ch0 at cycle 8 -> `resp_o`=A at cycle 8; `chan_resp_yumi_o`=01 at cycle 8, 10 at cycle 9; `resp_v_o`=0 in cycles 5–7.
- Full: `max_outstanding_p`=4, four commands with no responses -> `outstanding_o`=4 and `cmd_ready_o`=0 with `cmd_v_i`=1; one `resp_yumi_i` -> next cycle `cmd_ready_o`=1 and `outstanding_o`=3.
- Backpressure: `chan_cmd_ready_i[1]`=0, command to 0x40 -> `chan_cmd_v_o[1]`=1 held and `cmd_ready_o`=0; ready raised -> fire that cycle and `outstanding_o` increments.
- Contiguous mode: `num_channels_p`=4, `interleave_p`=0, `addr_width_p`=40, address 0xC0_0000_0000 -> `chan_cmd_v_o`=1000.
- Reset mid-operation: 3 outstanding, `reset_i` for 1 cycle -> `outstanding_o`=0, `resp_v_o`=0 even with `chan_resp_v_i` high; the next command pushes into FIFO entry 0.
